branch_predictor: RTL
=====================

# branch_predictor

Fetch-stage branch predictor that works opposite the execute-stage branch decision logic. It predicts at fetch and checks that prediction against the resolved outcome at execute. A direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB) supplies a taken/target guess for every fetched PC. Each guess is held in an in-flight queue until execute reports the real outcome (`take_branch` and target). On a wrong guess the block emits a registered flush/redirect to the PC mux and trains the tables.

## Interface
- `IDX_BITS`, 6: table index width; 2^IDX_BITS entries, indexed by `pc[IDX_BITS+1:2]`.
- `DEPTH`, 2: in-flight queue entries, power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `f_valid`  in  1  fetch presents a PC this cycle; push occurs on `f_valid & ~fifo_full`.
- `f_pc`  in  32  fetch PC, word aligned.
- `pred_taken`  out  1  combinational prediction for `f_pc`.
- `pred_target`  out  32  combinational predicted next PC: BTB target if `pred_taken`, else `f_pc+4`.
- `fifo_full`  out  1  queue full; fetch must stall.
- `r_valid`  in  1  execute resolves the oldest queued instruction (pop).
- `r_is_branch`  in  1  resolved instruction is a branch/jump.
- `r_taken`  in  1  resolved direction (`take_branch` from the execute stage).
- `r_target`  in  32  resolved taken target.
- `mispredict`  out  1  registered one-cycle flush pulse.
- `redirect_pc`  out  32  registered correct next PC; valid while `mispredict` is high.

## Operation
- **Table reset values:**
  - Counters reset to 2'b01 (weakly not-taken).
  - BTB valid bits reset to 0.
  - Queue is empty.
  - `mispredict` = 0, `redirect_pc` = 0.
- **Lookup:** `pred_taken = ctr[idx][1] & btb_v[idx] & (btb_tag[idx] == f_pc[31:IDX_BITS+2])`.
- **Push:** a push stores {pc, pred_taken, pred_target} at the queue tail.
- **Pop:** `r_valid` compares the head entry with the resolved outcome, in this priority order:
  - Branch whose taken-ness differs from the prediction → mispredict. `redirect_pc = r_taken ? r_target : pc+4`.
  - Branch taken with `r_target != pred_target` → mispredict. `redirect_pc = r_target`.
  - Non-branch predicted taken (aliasing) → mispredict. `redirect_pc = pc+4`.
  - Anything else → no mispredict.
- **Training, applied at the pop edge and indexed by head.pc:**
  - Branch: counter saturating +1 if taken, −1 if not taken. It stays at 3 and at 0 at the ends.
  - Branch taken: the BTB entry is written with tag, target and valid=1.
  - Non-branch that was predicted taken: BTB valid for that index is cleared.
- **Flush:** a mispredict empties the whole queue at the same edge. A push in that same cycle is discarded, because it is a wrong-path fetch. Pushes resume in the following cycle, the one in which `mispredict` is high.
- **Empty queue:** `r_valid` while the queue is empty is ignored, with no training and no mispredict.
- **Full queue:** a push is accepted when a pop happens in the same cycle. Otherwise a push while full is dropped.

## Timing
- Prediction is zero-latency, read combinationally from the table flops.
- Table writes become visible at the next edge. A lookup in the same cycle as a write to the same index sees the old value, with no bypass.
- `mispredict` and `redirect_pc` are asserted exactly one cycle after the `r_valid` cycle, for one cycle.
- `rst_n` low at any time, including mid-flush:
  - The queue, counters and BTB valid bits clear immediately.
  - `mispredict` drops immediately.

## Configuration
- `BRANCH_PRED_STATS_EN` defined:
  - Adds output `stat_branches` [31:0], counting `r_valid & r_is_branch` pops.
  - Adds output `stat_misses` [31:0], counting mispredicts.
  - Both wrap modulo 2^32 and reset to 0.
- `BRANCH_PRED_STATS_EN` undefined: those ports and counters do not exist, and all other behaviour is identical.

## Test plan
- **Reset defaults:** after reset, `f_pc=0x00400010` → `pred_taken=0`, `pred_target=0x00400014`. `mispredict=0`, `fifo_full=0`.
- **First-time taken branch:** push 0x00400020, then resolve it taken to 0x00400100.
  - Next cycle: `mispredict=1`, `redirect_pc=0x00400100`, queue empty.
  - Counter goes to 2, and a fresh lookup of 0x00400020 gives `pred_taken=1`, `pred_target=0x00400100`.
- **Saturation and hysteresis:** train the same PC taken 4 times, then not-taken once → still predicted taken (counter 2). Not-taken again → predicted not-taken.
- **Wrong target:** the entry predicts 0x00400100 but resolves taken to 0x00400200 → `mispredict=1`, `redirect_pc=0x00400200`, BTB updated.
- **Queue boundaries:** with `DEPTH=2`:
  - Push twice → `fifo_full=1`.
  - A third push without a pop is dropped.
  - Push and pop in the same cycle while full is accepted.
  - `r_valid` on an empty queue produces no mispredict.
- **Flush versus push, then reset:** a mispredicting pop and a push in the same cycle → the queue is empty afterwards. Assert `rst_n=0` during the `mispredict` cycle → `mispredict` clears asynchronously and the BTB entry reads invalid.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: 2-bit counters plus a tagged BTB, with an in-flight queue checked at execute.
// Optional hit/miss statistics counters are built when BRANCH_PRED_STATS_EN is defined.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        f_valid_i,
  input  logic [31:0] f_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic        fifo_full_o,
`ifdef BRANCH_PRED_STATS_EN
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_misses_o,
`endif
  input  logic        r_valid_i,
  input  logic        r_is_branch_i,
  input  logic        r_taken_i,
  input  logic [31:0] r_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;

  logic [1:0]        ctr_q     [ENTRIES];
  logic [ENTRIES-1:0] btb_v_q;
  logic [TAG_W-1:0]  btb_tag_q [ENTRIES];
  logic [31:0]       btb_tgt_q [ENTRIES];

  logic [31:0]       q_pc_q    [DEPTH];
  logic              q_pt_q    [DEPTH];
  logic [31:0]       q_tgt_q   [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              mispredict_q;
  logic [31:0]       redirect_q;

  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_W-1:0]    f_tag;
  logic                full, empty, pop, push;
  logic [31:0]         h_pc, h_tgt, h_pc4;
  logic                h_pt;
  logic [IDX_BITS-1:0] h_idx;
  logic [TAG_W-1:0]    h_tag;
  logic                miss_d;
  logic [31:0]         redirect_d;

  assign f_idx = f_pc_i[IDX_BITS+1:2];
  assign f_tag = f_pc_i[31:IDX_BITS+2];

  assign pred_taken_o  = ctr_q[f_idx][1] & btb_v_q[f_idx] & (btb_tag_q[f_idx] == f_tag);
  assign pred_target_o = pred_taken_o ? btb_tgt_q[f_idx] : f_pc_i + 32'd4;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign fifo_full_o = full;

  assign h_pc  = q_pc_q[head_q];
  assign h_pt  = q_pt_q[head_q];
  assign h_tgt = q_tgt_q[head_q];
  assign h_pc4 = h_pc + 32'd4;
  assign h_idx = h_pc[IDX_BITS+1:2];
  assign h_tag = h_pc[31:IDX_BITS+2];

  assign pop = r_valid_i & ~empty;

  always_comb begin
    miss_d     = 1'b0;
    redirect_d = h_pc4;
    if (pop) begin
      if (r_is_branch_i && (r_taken_i != h_pt)) begin
        miss_d     = 1'b1;
        redirect_d = r_taken_i ? r_target_i : h_pc4;
      end else if (r_is_branch_i && r_taken_i && (r_target_i != h_tgt)) begin
        miss_d     = 1'b1;
        redirect_d = r_target_i;
      end else if (!r_is_branch_i && h_pt) begin
        miss_d     = 1'b1;
        redirect_d = h_pc4;
      end
    end
  end

  // A push coinciding with a flush is a wrong-path fetch and is dropped.
  assign push = f_valid_i & (~full | pop) & ~miss_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
      btb_v_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= miss_d;
      if (miss_d) redirect_q <= redirect_d;

      if (miss_d) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (pop)  head_q <= head_q + 1'b1;
        if (push) tail_q <= tail_q + 1'b1;
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end

      if (pop) begin
        if (r_is_branch_i) begin
          if (r_taken_i && ctr_q[h_idx] != 2'b11)
            ctr_q[h_idx] <= ctr_q[h_idx] + 2'b01;
          else if (!r_taken_i && ctr_q[h_idx] != 2'b00)
            ctr_q[h_idx] <= ctr_q[h_idx] - 2'b01;
          if (r_taken_i) btb_v_q[h_idx] <= 1'b1;
        end else if (h_pt) begin
          btb_v_q[h_idx] <= 1'b0;
        end
      end
    end
  end

  // Tag/target storage needs no reset: the valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (pop && r_is_branch_i && r_taken_i) begin
      btb_tag_q[h_idx] <= h_tag;
      btb_tgt_q[h_idx] <= r_target_i;
    end
    if (push) begin
      q_pc_q[tail_q]  <= f_pc_i;
      q_pt_q[tail_q]  <= pred_taken_o;
      q_tgt_q[tail_q] <= pred_target_o;
    end
  end

  assign mispredict_o  = mispredict_q;
  assign redirect_pc_o = redirect_q;

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_br_q, stat_miss_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_br_q   <= '0;
      stat_miss_q <= '0;
    end else begin
      if (pop && r_is_branch_i) stat_br_q <= stat_br_q + 32'd1;
      if (miss_d) stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_misses_o   = stat_miss_q;
`endif

endmodule
